// File: rtl/maxnet_set_feeder.sv
// Maxnet set feeder: packs four samples into a set, launches the core, returns the winner or a timeout.
// Optional FEEDER_DOUBLE_BUF_EN adds a shadow buffer that accepts the next set while the core runs.
module maxnet_set_feeder #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                in_ready,
   output logic [4*DATA_W-1:0] set_x,
   output logic                core_start,
   input  logic                core_done,
   input  logic [DATA_W-1:0]   core_max,
   output logic                res_valid,
   output logic [DATA_W-1:0]   res_data,
   output logic                res_timeout,
   input  logic                res_ready,
   output logic                busy
);

   localparam int unsigned SET_N = 4;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [1:0]        fill_cnt_q, fill_cnt_d;
   logic [DATA_W-1:0] x_q [SET_N];
   logic [DATA_W-1:0] x_d [SET_N];
   logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
   logic              xfer;
   logic              in_ready_d, core_start_d, busy_d;
   logic              res_valid_d, res_timeout_d;
   logic [DATA_W-1:0] res_data_d;
`ifdef FEEDER_DOUBLE_BUF_EN
   logic [DATA_W-1:0] sh_q [SET_N];
   logic [DATA_W-1:0] sh_d [SET_N];
   logic [2:0]        sh_cnt_q, sh_cnt_d;
`endif

   // x0 sits in the least significant word
   for (genvar g = 0; g < SET_N; g++) begin : g_setx
      assign set_x[g*DATA_W +: DATA_W] = x_q[g];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_FILL;
         fill_cnt_q  <= '0;
         for (int k = 0; k < SET_N; k++) x_q[k] <= '0;
         wd_q        <= '0;
         in_ready    <= 1'b1;
         core_start  <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_timeout <= 1'b0;
         busy        <= 1'b0;
`ifdef FEEDER_DOUBLE_BUF_EN
         for (int k = 0; k < SET_N; k++) sh_q[k] <= '0;
         sh_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         x_q         <= x_d;
         wd_q        <= wd_d;
         in_ready    <= in_ready_d;
         core_start  <= core_start_d;
         res_valid   <= res_valid_d;
         res_data    <= res_data_d;
         res_timeout <= res_timeout_d;
         busy        <= busy_d;
`ifdef FEEDER_DOUBLE_BUF_EN
         sh_q        <= sh_d;
         sh_cnt_q    <= sh_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      fill_cnt_d    = fill_cnt_q;
      x_d           = x_q;
      wd_d          = wd_q;
      res_valid_d   = res_valid;
      res_data_d    = res_data;
      res_timeout_d = res_timeout;
      xfer          = in_valid & in_ready;
      wd_inc        = wd_q + WD_W'(1);
`ifdef FEEDER_DOUBLE_BUF_EN
      sh_d          = sh_q;
      sh_cnt_d      = sh_cnt_q;
      // outside FILL, accepted words queue up for the next set
      if (xfer && (state_q != S_FILL)) begin
         sh_d[sh_cnt_q[1:0]] = in_data;
         sh_cnt_d            = sh_cnt_q + 3'd1;
      end
`endif

      case (state_q)
         S_FILL: begin
            if (xfer) begin
               x_d[fill_cnt_q] = in_data;
               fill_cnt_d      = fill_cnt_q + 2'd1;
               if (fill_cnt_q == 2'd3) state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_inc;
            // wd_q == 0 marks the first WAIT cycle, when core_done is still stale
            if (core_done && (wd_q != '0)) begin
               res_data_d    = core_max;
               res_timeout_d = 1'b0;
               res_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end else if (wd_inc == WD_W'(TIMEOUT_CYC)) begin
               res_data_d    = '0;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_FILL;
`ifdef FEEDER_DOUBLE_BUF_EN
               for (int k = 0; k < SET_N; k++) begin
                  if (3'(k) < sh_cnt_d) x_d[k] = sh_d[k];
               end
               fill_cnt_d = sh_cnt_d[1:0];
               if (sh_cnt_d == 3'(SET_N)) state_d = S_LAUNCH;
               sh_cnt_d = '0;
`endif
            end
         end
         default: state_d = S_FILL;
      endcase

      core_start_d = (state_d == S_LAUNCH);
      busy_d       = (state_d != S_FILL);
`ifdef FEEDER_DOUBLE_BUF_EN
      in_ready_d   = (state_d == S_FILL) || (sh_cnt_d != 3'(SET_N));
`else
      in_ready_d   = (state_d == S_FILL);
`endif
   end

endmodule

// File: tb/tb_maxnet_set_feeder.sv
// Bench for maxnet_set_feeder: random sets, a behavioural core model and a result scoreboard.
module tb_maxnet_set_feeder;

   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [127:0]  set_x;
   logic          core_start;
   logic          core_done;
   logic [DW-1:0] core_max;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          res_timeout;
   logic          res_ready;
   logic          busy;

   maxnet_set_feeder #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .set_x(set_x), .core_start(core_start),
      .core_done(core_done), .core_max(core_max), .res_valid(res_valid),
      .res_data(res_data), .res_timeout(res_timeout), .res_ready(res_ready),
      .busy(busy)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last4_cyc = 0;
   int rr_mode = 2;             // 0 = hold low, 1 = random, 2 = always high

   logic [DW-1:0]  acc_q[$];    // words of the set currently being assembled
   logic [127:0]   set_exp_q[$];
   int             dly_q[$];    // core delay per set, 0 = never finishes
   logic [DW-1:0]  max_q[$];
   logic [DW:0]    res_exp_q[$]; // {timeout, data}

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s actual=timeout expected=event (t=%0t)", name, $time);
   endtask

   // Reference model of set assembly: every four accepted words form one set
   initial forever begin
      @(negedge clock);
      if (reset) acc_q.delete();
      else if (in_valid && in_ready) begin
         acc_q.push_back(in_data);
         if (acc_q.size() == 4) begin
            set_exp_q.push_back({acc_q[3], acc_q[2], acc_q[1], acc_q[0]});
            acc_q.delete();
            last4_cyc = cyc;
         end
      end
   end

   // Core model: on each start checks the presented set, then answers after the chosen delay
   initial begin
      core_done = 1'b0;
      core_max  = '0;
      forever begin
         @(negedge clock);
         if (!reset && core_start) begin
            int dly, n;
            logic [DW-1:0] mx;
            chk("start_latency", 128'(cyc - last4_cyc), 128'(1));
            chk("start_busy", 128'(busy), 128'(1));
            if (set_exp_q.size() == 0) bound_fail("set_expected");
            else chk("set_x", set_x, set_exp_q.pop_front());
            if (dly_q.size() == 0) begin
               bound_fail("core_plan");
               dly = 0;
               mx  = '0;
            end else begin
               dly = dly_q.pop_front();
               mx  = max_q.pop_front();
            end
            res_exp_q.push_back((dly == 0) ? {1'b1, {DW{1'b0}}} : {1'b0, mx});
            n = 0;
            forever begin
               @(negedge clock);
               n++;
               if (reset) break;
               chk("single_start", 128'(core_start), 128'(0));
               if (res_valid) begin
                  chk("res_latency", 128'(n), 128'((dly == 0) ? TO + 1 : dly + 1));
                  break;
               end
               if (dly != 0 && n == dly) begin
                  core_done = 1'b1;
                  core_max  = mx;
               end
               if (n > int'(TO) + 3) begin
                  bound_fail("res_valid_wait");
                  break;
               end
            end
            core_done = 1'b0;
            core_max  = $urandom;
         end
      end
   end

   // Result monitor: pops expected results on handshake and checks stability while stalled
   initial begin
      logic          prev_v, prev_hs;
      logic [DW:0]   prev_p;
      prev_v = 1'b0;
      prev_hs = 1'b0;
      prev_p = '0;
      forever begin
         @(negedge clock);
         if (reset) prev_v = 1'b0;
         else begin
            if (prev_v && !prev_hs) begin
               chk("hold_valid", 128'(res_valid), 128'(1));
               chk("hold_payload", 128'({res_timeout, res_data}), 128'(prev_p));
            end
            if (res_valid) chk("busy_hold", 128'(busy), 128'(1));
            if (res_valid && res_ready) begin
               if (res_exp_q.size() == 0) bound_fail("res_expected");
               else chk("result", 128'({res_timeout, res_data}), 128'(res_exp_q.pop_front()));
            end
            prev_v  = res_valid;
            prev_hs = res_valid && res_ready;
            prev_p  = {res_timeout, res_data};
         end
      end
   end

   // Downstream ready pattern
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         res_ready = (rr_mode == 2) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the word is taken
   task automatic send_word(input logic [DW-1:0] d);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      @(negedge clock);
      while (!in_ready) begin
         t++;
         if (t > 500) begin
            bound_fail("in_ready_wait");
            break;
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_set(input logic [DW-1:0] w0, w1, w2, w3, input int dly,
                           input logic [DW-1:0] mx, input bit gaps);
      logic [DW-1:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      dly_q.push_back(dly);
      max_q.push_back(mx);
      for (int i = 0; i < 4; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
         send_word(w[i]);
      end
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      @(negedge clock);
      while (res_exp_q.size() != 0 || busy || set_exp_q.size() != 0) begin
         t++;
         if (t > budget) begin
            bound_fail("idle_wait");
            break;
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_set_x", set_x, 128'(0));
      chk("rst_core_start", 128'(core_start), 128'(0));
      chk("rst_res_valid", 128'(res_valid), 128'(0));
      chk("rst_res_data", 128'(res_data), 128'(0));
      chk("rst_res_timeout", 128'(res_timeout), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clock);
      #1;

      // partial set discarded by reset, then a fresh set
      send_word(32'hDEAD0001);
      send_word(32'hDEAD0002);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("midrst_set_x", set_x, 128'(0));
      @(posedge clock);
      #1;
      send_set(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3, 32'h44444444, 1'b0);
      wait_idle(200);

      // basic set
      send_set(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 5, 32'h40400000, 1'b0);
      wait_idle(200);

      // backpressure on the result port
      rr_mode = 0;
      send_set($urandom, $urandom, $urandom, $urandom, 4, 32'h12345678, 1'b0);
      begin
         int t;
         t = 0;
         @(negedge clock);
         while (!res_valid && t < 100) begin t++; @(negedge clock); end
         if (!res_valid) bound_fail("bp_res_valid");
         repeat (10) begin
`ifndef FEEDER_DOUBLE_BUF_EN
            chk("bp_in_ready", 128'(in_ready), 128'(0));
`endif
            chk("bp_res_valid", 128'(res_valid), 128'(1));
            @(negedge clock);
         end
      end
      rr_mode = 2;
      wait_idle(200);

      // watchdog abort
      send_set(32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 0, '0, 1'b0);
      wait_idle(200);

      // random sets with random gaps, delays and ready pattern
      rr_mode = 1;
      for (int s = 0; s < 20; s++) begin
         int d;
         d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 12));
         send_set($urandom, $urandom, $urandom, $urandom, d, $urandom, 1'b1);
      end
      wait_idle(3000);
      rr_mode = 2;

      chk("sets_drained", 128'(set_exp_q.size()), 128'(0));
      chk("plans_drained", 128'(dly_q.size()), 128'(0));
      chk("results_drained", 128'(res_exp_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
